// File: rtl/step_counter.sv
// Signed step counter: clamps at MIN and MAX, always skips over the forbidden value INV, and has a clamped load.
// Define STEP_COUNTER_WRAP_EN to make an up/down step wrap to MIN/MAX instead of holding.
module step_counter #(
  parameter int WIDTH   = 10,
  parameter int MIN     = -230,
  parameter int MAX     = 235,
  parameter int INV     = -11,
  parameter int STEP_UP = 5,
  parameter int STEP_DN = 9,
  parameter int RST_VAL = -50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);

  // Two guard bits keep the sum and the skip target from overflowing.
  typedef logic signed [WIDTH+1:0] ext_t;

  localparam ext_t P_MIN = ext_t'(MIN);
  localparam ext_t P_MAX = ext_t'(MAX);
  localparam ext_t P_INV = ext_t'(INV);
  localparam ext_t P_UP  = ext_t'(STEP_UP);
  localparam ext_t P_DN  = ext_t'(STEP_DN);
  localparam ext_t P_RST = ext_t'(RST_VAL);

  ext_t cur, lv, tgt, nxt_cnt;
  logic nxt_sat;

  always_comb begin
    cur     = {{2{cnt[WIDTH-1]}}, cnt};
    lv      = {{2{load_val[WIDTH-1]}}, load_val};
    tgt     = cur;
    nxt_cnt = cur;
    nxt_sat = 1'b0;
    if (load) begin
      if (lv < P_MIN)      tgt = P_MIN;
      else if (lv > P_MAX) tgt = P_MAX;
      else                 tgt = lv;
      if (tgt == P_INV)    tgt = P_INV + ext_t'(1);
      nxt_cnt = tgt;
      nxt_sat = (tgt != lv);
    end else if (en) begin
      if (mode) begin
        tgt = cur + P_UP;
        if (tgt == P_INV) tgt = tgt + P_UP;
        if (tgt > P_MAX) begin
          nxt_sat = 1'b1;
`ifdef STEP_COUNTER_WRAP_EN
          nxt_cnt = P_MIN;
`else
          nxt_cnt = cur;
`endif
        end else begin
          nxt_cnt = tgt;
        end
      end else begin
        tgt = cur - P_DN;
        if (tgt == P_INV) tgt = tgt - P_DN;
        if (tgt < P_MIN) begin
          nxt_sat = 1'b1;
`ifdef STEP_COUNTER_WRAP_EN
          nxt_cnt = P_MAX;
`else
          nxt_cnt = cur;
`endif
        end else begin
          nxt_cnt = tgt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= P_RST[WIDTH-1:0];
      sat <= 1'b0;
    end else begin
      cnt <= nxt_cnt[WIDTH-1:0];
      sat <= nxt_sat;
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter: directed cases, then random traffic checked against an integer model.
module tb_step_counter;
  localparam int W = 10, MIN = -230, MAX = 235, INV = -11, UP = 5, DN = 9, RV = -50;
`ifdef STEP_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] cnt;
  logic sat;

  step_counter dut (.clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
                    .load_val(load_val), .cnt(cnt), .sat(sat));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_cnt = RV, m_sat = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dcnt();
    return int'($signed(cnt));
  endfunction

  // Reference: each step goes to the next legal value in its direction, and a step that leaves [MIN,MAX] is refused.
  function automatic void model(input bit r, input bit e, input bit md, input bit ld, input int lv);
    int t;
    if (r) begin m_cnt = RV; m_sat = 0; end
    else if (ld) begin
      t = (lv < MIN) ? MIN : (lv > MAX) ? MAX : lv;
      if (t == INV) t = INV + 1;
      m_sat = (t != lv) ? 1 : 0;
      m_cnt = t;
    end else if (e) begin
      t = md ? m_cnt + UP : m_cnt - DN;
      if (t == INV) t = md ? t + UP : t - DN;
      if (t > MAX || t < MIN) begin
        m_sat = 1;
        if (WRAP) m_cnt = md ? MIN : MAX;
      end else begin
        m_cnt = t; m_sat = 0;
      end
    end else m_sat = 0;
  endfunction

  task automatic step(input bit r, input bit e, input bit md, input bit ld, input int lv, input string tag);
    @(negedge clk);
    rst = r; en = e; mode = md; load = ld; load_val = W'(lv);
    @(posedge clk);
    #1;
    model(r, e, md, ld, int'($signed(W'(lv))));
    chk({tag, ".cnt"}, dcnt(), m_cnt);
    chk({tag, ".sat"}, int'(sat), m_sat);
  endtask

  initial begin
    int prev, d, lvr;
    bit r, e, md, ld, legal;

    // Directed cases, each also checked against a hand-worked constant.
    step(1, 0, 0, 0, 0, "rst");   chk("rst_c", dcnt(), -50); chk("rst_s", int'(sat), 0);
    step(0, 0, 0, 0, 0, "hold");  chk("hold_c", dcnt(), -50); chk("hold_s", int'(sat), 0);
    step(0, 1, 1, 0, 0, "up");    chk("up_c", dcnt(), -45);
    step(0, 0, 0, 1, -16, "ld16"); chk("ld16_c", dcnt(), -16);
    step(0, 1, 1, 0, 0, "upskip"); chk("upskip_c", dcnt(), -6); chk("upskip_s", int'(sat), 0);
    step(0, 0, 0, 1, -2, "ld2");
    step(0, 1, 0, 0, 0, "dnskip"); chk("dnskip_c", dcnt(), -20); chk("dnskip_s", int'(sat), 0);
    step(0, 0, 0, 1, 232, "ld232");
    step(0, 1, 1, 0, 0, "ovf");   chk("ovf_c", dcnt(), WRAP ? -230 : 232); chk("ovf_s", int'(sat), 1);
    step(0, 0, 0, 1, -225, "ldm225");
    step(0, 1, 0, 0, 0, "unf");   chk("unf_c", dcnt(), WRAP ? 235 : -225); chk("unf_s", int'(sat), 1);
    step(0, 0, 0, 1, 400, "ld400"); chk("ld400_c", dcnt(), 235); chk("ld400_s", int'(sat), 1);
    step(0, 0, 0, 1, -500, "ldm500"); chk("ldm500_c", dcnt(), -230); chk("ldm500_s", int'(sat), 1);
    step(0, 0, 0, 1, -11, "ldinv"); chk("ldinv_c", dcnt(), -10); chk("ldinv_s", int'(sat), 1);
    step(1, 1, 1, 1, 100, "rstld"); chk("rstld_c", dcnt(), -50); chk("rstld_s", int'(sat), 0);
    step(0, 1, 1, 1, 100, "ldwin"); chk("ldwin_c", dcnt(), 100); chk("ldwin_s", int'(sat), 0);

    // Random traffic: model match, range invariant and allowed per-step deltas.
    for (int i = 0; i < 10000; i++) begin
      prev = dcnt();
      r  = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 1);
      lvr = int'($signed(W'($urandom_range(0, 1023))));
      step(r, e, md, ld, lvr, "rnd");
      chk("inv", int'(dcnt() >= MIN && dcnt() <= MAX && dcnt() != INV), 1);
      if (!r && !ld) begin
        d = dcnt() - prev;
        legal = (d == 0) || (e && md && (d == UP || d == 2*UP)) ||
                (e && !md && (d == -DN || d == -2*DN)) ||
                (WRAP && e && (dcnt() == (md ? MIN : MAX)));
        chk("delta", int'(legal), 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 Parameter WIDTH, 10, counter width in bits (signed two's complement).
REQ-002 Parameter MIN, -230, lowest legal count.
REQ-003 Parameter MAX, 235, highest legal count.
REQ-004 Parameter INV, -11, forbidden value the count SHALL never hold.
REQ-005 Parameter STEP_UP, 5, increment per enabled up step.
REQ-006 Parameter STEP_DN, 9, decrement per enabled down step.
REQ-007 Parameter RST_VAL, -50, count after reset.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 en  input  1  step enable; 0 = hold.
REQ-011 mode  input  1  1 = count up, 0 = count down.
REQ-012 load  input  1  load request; priority over en.
REQ-013 load_val  input  WIDTH  signed value to load.
REQ-014 cnt  output  WIDTH  signed registered count.
REQ-015 sat  output  1  registered pulse: the previous cycle's step or load was blocked or clamped.

Function
REQ-016 Legal parameter set SHALL satisfy MIN < INV < MAX, MIN <= RST_VAL <= MAX, RST_VAL != INV, STEP_UP >= 1, STEP_DN >= 1; all values fit WIDTH bits signed.
REQ-017 Next-count arithmetic SHALL be done in WIDTH+2 signed bits; no intermediate overflow.
REQ-018 Priority per cycle: rst > load > en > hold.
REQ-019 Hold (en=0, load=0): cnt unchanged, sat=0.
REQ-020 Up step, normal: cnt+STEP_UP <= MAX and != INV -> cnt += STEP_UP, sat=0.
REQ-021 Up step, skip: cnt+STEP_UP == INV -> target INV+STEP_UP; if target <= MAX cnt = target, sat=0.
REQ-022 Up step, overflow: effective target > MAX -> cnt unchanged, sat=1 next cycle.
REQ-023 Down step, normal: cnt-STEP_DN >= MIN and != INV -> cnt -= STEP_DN, sat=0.
REQ-024 Down step, skip: cnt-STEP_DN == INV -> target INV-STEP_DN; if target >= MIN cnt = target, sat=0.
REQ-025 Down step, underflow: effective target < MIN -> cnt unchanged, sat=1 next cycle.
REQ-026 Load: load_val clamped to [MIN,MAX]; clamped value == INV -> INV+1; sat=1 if any adjustment made, else 0.
REQ-027 Latency: cnt and sat update exactly one clock after the sampled inputs; no combinational path from inputs to outputs.
REQ-028 Invariant: MIN <= cnt <= MAX and cnt != INV in every cycle after reset.

Reset
REQ-029 rst=1 at a clock edge SHALL set cnt=RST_VAL and sat=0, regardless of load/en/mode.
REQ-030 Reset mid-operation SHALL discard any step or load sampled in the same cycle; first step is taken from the first edge with rst=0.

Configuration
REQ-031 Macro STEP_COUNTER_WRAP_EN: when defined, up overflow (REQ-022) sets cnt=MIN and down underflow (REQ-025) sets cnt=MAX, sat=1 in both cases; MIN/MAX SHALL never equal INV, so no skip applies after wrap.
REQ-032 Without STEP_COUNTER_WRAP_EN the counter saturates (holds) per REQ-022/REQ-025; load behaviour is identical in both builds.

Verification
REQ-033 Default params: rst 1 cycle, then hold -> cnt=-50, sat=0; one up step -> cnt=-45.
REQ-034 load load_val=-16, then up step -> cnt=-6 (skips -11), sat=0; load -2, down step -> cnt=-20.
REQ-035 load 232, up step -> cnt=232, sat=1; load -225, down step -> cnt=-225, sat=1; with WRAP_EN -> cnt=-230 then 235 respectively.
REQ-036 load 400 -> cnt=235, sat=1; load -500 -> cnt=-230, sat=1; load -11 -> cnt=-10, sat=1.
REQ-037 rst=1 with load=1, load_val=100, en=1 -> cnt=-50, sat=0; load and en both high -> load wins.
REQ-038 Random en/mode/load for 10k cycles -> REQ-028 invariant and per-step deltas (+5, +10, -9, -18, 0 or wrap) hold every cycle.
